// File: rtl/sha256_round_engine_if.sv
// Block-in / digest-out handshake bundle for sha256_round_engine.
// The master side is the block source and digest sink. The slave side is the engine.
interface sha256_round_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_block;
  logic [255:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_state;
  logic         busy;

  modport master (
    output in_valid, in_block, in_state, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_block, in_state, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/sha256_round_engine.sv
// Iterative SHA-256 compression engine that runs UNROLL rounds per clock over 64 rounds.
// Define SHA256_FEEDFWD_EN to add the chaining value (Davies-Meyer) inside the engine.
module sha256_round_engine #(
  parameter int unsigned UNROLL = 1
) (
  input logic                  clk,
  input logic                  rst,
  sha256_round_engine_if.slave bus
);

  localparam int unsigned NCYC = 64 / UNROLL;

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $error("sha256_round_engine: UNROLL=%0d is not one of 1,2,4,8 (NCYC=%0d)", UNROLL, NCYC);
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef logic [31:0] word_t;
  typedef word_t [0:7]  hash_t;   // [0] = A / H0, most significant word
  typedef word_t [0:15] sched_t;  // [0] = W[rnd], most significant word

  localparam word_t K_ROM [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(word_t x, int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t big_s0(word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_s1(word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_s0(word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_s1(word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic hash_t sha_round(hash_t s, word_t k, word_t w);
    word_t t1;
    word_t t2;
    hash_t r;
    t1   = s[7] + big_s1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
    t2   = big_s0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    r[0] = t1 + t2;
    r[1] = s[0];
    r[2] = s[1];
    r[3] = s[2];
    r[4] = s[3] + t1;
    r[5] = s[4];
    r[6] = s[5];
    r[7] = s[6];
    return r;
  endfunction

  // Chain UNROLL rounds; window word i is W[base+i].
  function automatic hash_t run_rounds(hash_t s, sched_t w, logic [5:0] base);
    hash_t r;
    r = s;
    for (int i = 0; i < UNROLL; i++) begin
      r = sha_round(r, K_ROM[base + 6'(i)], w[i]);
    end
    return r;
  endfunction

  // Extend the window by UNROLL words, then drop the UNROLL oldest.
  function automatic sched_t sched_advance(sched_t w);
    word_t  x [0:15+UNROLL];
    sched_t r;
    for (int j = 0; j < 16; j++) begin
      x[j] = w[j];
    end
    for (int j = 16; j < 16 + UNROLL; j++) begin
      x[j] = small_s1(x[j-2]) + x[j-7] + small_s0(x[j-15]) + x[j-16];
    end
    for (int j = 0; j < 16; j++) begin
      r[j] = x[j+UNROLL];
    end
    return r;
  endfunction

  state_e     state_q, state_d;
  logic [6:0] rnd_q, rnd_d;
  hash_t      work_q, work_d;
  sched_t     sched_q, sched_d;
  hash_t      out_q, out_d;
`ifdef SHA256_FEEDFWD_EN
  hash_t      chain_q, chain_d;
`endif

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d = state_q;
    rnd_d   = rnd_q;
    work_d  = work_q;
    sched_d = sched_q;
    out_d   = out_q;
`ifdef SHA256_FEEDFWD_EN
    chain_d = chain_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = S_RUN;
          rnd_d   = '0;
          work_d  = hash_t'(bus.in_state);
          sched_d = sched_t'(bus.in_block);
`ifdef SHA256_FEEDFWD_EN
          chain_d = hash_t'(bus.in_state);
`endif
        end
      end
      S_RUN: begin
        work_d  = run_rounds(work_q, sched_q, rnd_q[5:0]);
        sched_d = sched_advance(sched_q);
        rnd_d   = rnd_q + 7'(UNROLL);
        if (rnd_d == 7'd64) begin
          state_d = S_DONE;
`ifdef SHA256_FEEDFWD_EN
          for (int i = 0; i < 8; i++) begin
            out_d[i] = work_d[i] + chain_q[i];
          end
`else
          out_d = work_d;
`endif
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the schedule window and working registers are plain flops, so they are
  // cleared on reset like everything else rather than treated as an unreset memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      work_q  <= '0;
      sched_q <= '0;
      out_q   <= '0;
`ifdef SHA256_FEEDFWD_EN
      chain_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      rnd_q   <= rnd_d;
      work_q  <= work_d;
      sched_q <= sched_d;
      out_q   <= out_d;
`ifdef SHA256_FEEDFWD_EN
      chain_q <= chain_d;
`endif
    end
  end

  // Reset masks the handshake and result outputs immediately.
  assign bus.in_ready  = (state_q == S_IDLE) && !rst;
  assign bus.out_valid = (state_q == S_DONE) && !rst;
  assign bus.busy      = (state_q != S_IDLE) && !rst;
  assign bus.out_state = rst ? '0 : out_q;

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench for sha256_round_engine: known-answer digests, latency, handshake and reset.
// Three engines (UNROLL 1/4/8) share the block inputs; UNROLL=1 is the main target.
module tb_sha256_round_engine;

`ifdef SHA256_FEEDFWD_EN
  localparam bit FEEDFWD = 1'b1;
`else
  localparam bit FEEDFWD = 1'b0;
`endif

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [255:0] DIG_ABC = {
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [511:0] BLK_M1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_M2 = {{15{32'h0}}, 32'h000001c0};
  localparam logic [255:0] DIG_M = {
    32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
    32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [511:0] in_block;
  logic [255:0] in_state;
  logic         out_ready;

  int checks   = 0;
  int failures = 0;

  sha256_round_engine_if if1 ();
  sha256_round_engine_if if4 ();
  sha256_round_engine_if if8 ();

  assign if1.in_valid  = in_valid;
  assign if1.in_block  = in_block;
  assign if1.in_state  = in_state;
  assign if1.out_ready = out_ready;
  assign if4.in_valid  = in_valid;
  assign if4.in_block  = in_block;
  assign if4.in_state  = in_state;
  assign if4.out_ready = 1'b1;
  assign if8.in_valid  = in_valid;
  assign if8.in_block  = in_block;
  assign if8.in_state  = in_state;
  assign if8.out_ready = 1'b1;

  sha256_round_engine #(.UNROLL(1)) u_eng1 (.clk(clk), .rst(rst), .bus(if1.slave));
  sha256_round_engine #(.UNROLL(4)) u_eng4 (.clk(clk), .rst(rst), .bus(if4.slave));
  sha256_round_engine #(.UNROLL(8)) u_eng8 (.clk(clk), .rst(rst), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wordwise modulo-2^32 helpers for the external chaining arithmetic.
  function automatic logic [255:0] add256(logic [255:0] a, logic [255:0] b);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32];
    return r;
  endfunction

  function automatic logic [255:0] sub256(logic [255:0] a, logic [255:0] b);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = a[i*32 +: 32] - b[i*32 +: 32];
    return r;
  endfunction

  task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  bit           seen4, seen8;
  int           lat4, lat8;
  logic [255:0] res4, res8;

  // Present a block for one accept edge, scramble the inputs, then wait for DONE
  // with out_ready low so the engine is left holding its result.
  task automatic run_block(input logic [511:0] blk, input logic [255:0] st,
                           output logic [255:0] res, output int lat);
    in_block = blk;
    in_state = st;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_block = {16{32'hdeadbeef}};
    in_state = {8{32'h5a5a5a5a}};
    lat = 0;
    while (!if1.out_valid && lat < 200) begin
      tick();
      lat++;
      if (!seen4 && if4.out_valid) begin seen4 = 1'b1; lat4 = lat; res4 = if4.out_state; end
      if (!seen8 && if8.out_valid) begin seen8 = 1'b1; lat8 = lat; res8 = if8.out_state; end
      in_valid = (lat == 10);
      if (lat == 32) begin
        check("busy_in_run", 256'(if1.busy), 256'(1));
        check("in_ready_in_run", 256'(if1.in_ready), 256'(0));
      end
    end
    res = if1.out_state;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_after_hs", 256'(if1.out_valid), 256'(0));
    check("in_ready_after_hs", 256'(if1.in_ready), 256'(1));
  endtask

  initial begin
    logic [255:0] exp_abc, res, held, chain1, fin;
    int           lat;
    bit           any_valid;

    exp_abc   = FEEDFWD ? DIG_ABC : sub256(DIG_ABC, IV);
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_block  = '0;
    in_state  = '0;
    out_ready = 1'b0;
    seen4     = 1'b0;
    seen8     = 1'b0;
    lat4      = 0;
    lat8      = 0;
    res4      = '0;
    res8      = '0;

    // Reset state
    tick();
    check("rst_in_ready", 256'(if1.in_ready), 256'(0));
    check("rst_out_valid", 256'(if1.out_valid), 256'(0));
    check("rst_out_state", if1.out_state, 256'(0));
    check("rst_busy", 256'(if1.busy), 256'(0));
    tick();
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 256'(if1.in_ready), 256'(1));

    // "abc" on all three unroll factors
    run_block(BLK_ABC, IV, res, lat);
    check("abc_latency_u1", 256'(lat), 256'(64));
    check("abc_digest_u1", res, exp_abc);
    check("abc_latency_u4", 256'(lat4), 256'(16));
    check("abc_digest_u4", res4, exp_abc);
    check("abc_latency_u8", 256'(lat8), 256'(8));
    check("abc_digest_u8", res8, exp_abc);

    // Hold the result with out_ready low for 10 cycles
    held = if1.out_state;
    repeat (10) tick();
    check("hold_out_valid", 256'(if1.out_valid), 256'(1));
    check("hold_out_state", if1.out_state, held);
    check("hold_in_ready", 256'(if1.in_ready), 256'(0));
    check("hold_busy", 256'(if1.busy), 256'(1));
    release_out();

    // Two-block message, chaining block 1 into block 2
    run_block(BLK_M1, IV, res, lat);
    check("m1_latency", 256'(lat), 256'(64));
    chain1 = FEEDFWD ? res : add256(res, IV);
    release_out();
    run_block(BLK_M2, chain1, res, lat);
    check("m2_latency", 256'(lat), 256'(64));
    fin = FEEDFWD ? res : add256(res, chain1);
    check("two_block_digest", fin, DIG_M);
    release_out();

    // Reset in the middle of RUN at rnd=20
    in_block = BLK_ABC;
    in_state = IV;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 256'(if1.out_valid), 256'(0));
    check("midrst_in_ready", 256'(if1.in_ready), 256'(0));
    check("midrst_busy", 256'(if1.busy), 256'(0));
    tick();
    rst = 1'b0;
    #1;
    check("midrst_in_ready_release", 256'(if1.in_ready), 256'(1));
    check("midrst_busy_release", 256'(if1.busy), 256'(0));
    check("midrst_out_state", if1.out_state, 256'(0));
    any_valid = 1'b0;
    repeat (70) begin
      tick();
      if (if1.out_valid) any_valid = 1'b1;
    end
    check("midrst_no_output", 256'(any_valid), 256'(0));

    // Re-run "abc" after the aborted block
    run_block(BLK_ABC, IV, res, lat);
    check("rerun_latency", 256'(lat), 256'(64));
    check("rerun_digest", res, exp_abc);
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
